mem_byte_port: RTL and testbench

//  - Load/store adapter between the CPU data path and the single 16-bit-wide synchronous memory.
//  - Takes byte or halfword requests on byte addresses.
//  - Drives the memory word port, using read-modify-write for byte stores.
//  - Sits directly upstream of memory; its mem_* side maps 1:1 onto addr/en/rd_en/wr_en/din/dout.

---
 rtl/mem_byte_port_pkg.sv | 24 ++
 rtl/mem_byte_port_if.sv | 35 +++
 rtl/mem_byte_port_lane.sv | 35 +++
 rtl/mem_byte_port.sv | 165 ++++++++++++++++
 tb/tb_mem_byte_port.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_byte_port_pkg.sv
// Shared types and constants for the mem_byte_port load/store adapter.
// Used by mem_byte_port and mem_byte_lane; the alignment check is selected by MEM_BYTE_PORT_ALIGN_CHECK_EN.
package mem_byte_port_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    ERR     = 3'd4
  } state_t;

  typedef enum logic {
    SZ_BYTE = 1'b0,
    SZ_HALF = 1'b1
  } size_t;

  localparam int LANE_W = 8;

  function automatic logic [2*LANE_W-1:0] zext_byte(input logic [LANE_W-1:0] b);
    return {{LANE_W{1'b0}}, b};
  endfunction

endpackage

// File: rtl/mem_byte_port_if.sv
// CPU request/response and memory word-port signals of mem_byte_port.
// slave is the adapter side; master is the CPU plus memory environment side.
interface mem_byte_port_if #(
  parameter int ADDR_WIDTH = 12
);

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic                  req_size_i;
  logic [ADDR_WIDTH:0]   req_addr_i;
  logic [15:0]           req_wdata_i;
  logic                  rsp_valid_o;
  logic [15:0]           rsp_rdata_o;
  logic                  rsp_err_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_enable_o;
  logic                  mem_rd_en_o;
  logic                  mem_wr_en_o;
  logic [15:0]           mem_value_o;
  logic [15:0]           mem_value_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i, mem_value_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_addr_o, mem_enable_o, mem_rd_en_o, mem_wr_en_o, mem_value_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i, mem_value_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_addr_o, mem_enable_o, mem_rd_en_o, mem_wr_en_o, mem_value_o
  );

endinterface

// File: rtl/mem_byte_port_lane.sv
// Combinational lane logic: load extract with zero-extend, and byte merge for read-modify-write.
module mem_byte_lane
  import mem_byte_port_pkg::*;
(
  input  logic                  lane_sel,
  input  size_t                 size,
  input  logic [2*LANE_W-1:0]   rd_word,
  input  logic [LANE_W-1:0]     wr_byte,
  output logic [2*LANE_W-1:0]   ld_data,
  output logic [2*LANE_W-1:0]   merged
);

  // load data: whole word for halfwords, selected byte zero-extended otherwise
  always_comb begin
    ld_data = {(2*LANE_W){1'b0}};
    if (size == SZ_HALF) begin
      ld_data = rd_word;
    end else if (lane_sel) begin
      ld_data = zext_byte(rd_word[2*LANE_W-1:LANE_W]);
    end else begin
      ld_data = zext_byte(rd_word[LANE_W-1:0]);
    end
  end

  // store merge: the untouched lane keeps the value read from memory
  always_comb begin
    merged = rd_word;
    if (lane_sel) begin
      merged = {wr_byte, rd_word[LANE_W-1:0]};
    end else begin
      merged = {rd_word[2*LANE_W-1:LANE_W], wr_byte};
    end
  end

endmodule

// File: rtl/mem_byte_port.sv
// Byte/halfword load-store adapter onto a 16-bit synchronous memory, byte stores via read-modify-write.
// Define MEM_BYTE_PORT_ALIGN_CHECK_EN to reject misaligned halfwords with an error response.
module mem_byte_port
  import mem_byte_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic            clk_i,
  input  logic            rst_i,
  mem_byte_port_if.slave  bus
);

  state_t              state_r;
  state_t              state_s;
  logic                we_r;
  size_t               size_r;
  logic [ADDR_WIDTH:0] addr_r;
  logic [15:0]         wdata_r;
  logic [15:0]         merge_r;

  logic                accept_s;
  logic                misaligned_s;
  logic [15:0]         ld_data_s;
  logic [15:0]         merged_s;

  logic                ready_s;
  logic                rsp_valid_s;
  logic [15:0]         rsp_rdata_s;
  logic                rsp_err_s;
  logic                rd_en_s;
  logic                wr_en_s;
  logic [15:0]         mem_value_s;

  assign accept_s = bus.req_valid_i & ready_s;

`ifdef MEM_BYTE_PORT_ALIGN_CHECK_EN
  assign misaligned_s = (size_t'(bus.req_size_i) == SZ_HALF) & bus.req_addr_i[0];
`else
  assign misaligned_s = 1'b0;
`endif

  mem_byte_lane u_lane (
    .lane_sel (addr_r[0]),
    .size     (size_r),
    .rd_word  (bus.mem_value_i),
    .wr_byte  (wdata_r[LANE_W-1:0]),
    .ld_data  (ld_data_s),
    .merged   (merged_s)
  );

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // request latch on accept, merged word captured in RD_WAIT of a byte store
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_r    <= 1'b0;
      size_r  <= SZ_BYTE;
      addr_r  <= '0;
      wdata_r <= 16'h0000;
      merge_r <= 16'h0000;
    end else begin
      if (accept_s) begin
        we_r    <= bus.req_we_i;
        size_r  <= size_t'(bus.req_size_i);
        addr_r  <= bus.req_addr_i;
        wdata_r <= bus.req_wdata_i;
      end
      if ((state_r == RD_WAIT) && we_r) begin
        merge_r <= merged_s;
      end
    end
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_s = IDLE;
        end else if (misaligned_s) begin
          state_s = ERR;
        end else if (bus.req_we_i && (size_t'(bus.req_size_i) == SZ_HALF)) begin
          state_s = WR;
        end else begin
          state_s = RD;
        end
      end
      RD:      state_s = RD_WAIT;
      RD_WAIT: begin
        if (we_r) begin
          state_s = WR;
        end else begin
          state_s = IDLE;
        end
      end
      WR:      state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // outputs decoded from state; reset masks every strobe and the response immediately
  always_comb begin
    ready_s     = 1'b0;
    rsp_valid_s = 1'b0;
    rsp_rdata_s = 16'h0000;
    rsp_err_s   = 1'b0;
    rd_en_s     = 1'b0;
    wr_en_s     = 1'b0;
    mem_value_s = 16'h0000;
    if (!rst_i) begin
      case (state_r)
        IDLE: ready_s = 1'b1;
        RD:   rd_en_s = 1'b1;
        RD_WAIT: begin
          if (!we_r) begin
            rsp_valid_s = 1'b1;
            rsp_rdata_s = ld_data_s;
          end else begin
            rsp_valid_s = 1'b0;
          end
        end
        WR: begin
          wr_en_s     = 1'b1;
          rsp_valid_s = 1'b1;
          if (size_r == SZ_HALF) begin
            mem_value_s = wdata_r;
          end else begin
            mem_value_s = merge_r;
          end
        end
        ERR: begin
          rsp_valid_s = 1'b1;
`ifdef MEM_BYTE_PORT_ALIGN_CHECK_EN
          rsp_err_s   = 1'b1;
`else
          rsp_err_s   = 1'b0;
`endif
        end
        default: ready_s = 1'b0;
      endcase
    end else begin
      ready_s = 1'b0;
    end
  end

  assign bus.req_ready_o  = ready_s;
  assign bus.rsp_valid_o  = rsp_valid_s;
  assign bus.rsp_rdata_o  = rsp_rdata_s;
  assign bus.rsp_err_o    = rsp_err_s;
  assign bus.mem_addr_o   = addr_r[ADDR_WIDTH:1];
  assign bus.mem_rd_en_o  = rd_en_s;
  assign bus.mem_wr_en_o  = wr_en_s;
  assign bus.mem_enable_o = rd_en_s | wr_en_s;
  assign bus.mem_value_o  = mem_value_s;

endmodule

// File: tb/tb_mem_byte_port.sv
// Self-checking bench for mem_byte_port: directed and random requests against a word-array reference.
module tb_mem_byte_port;

  localparam int AW = 12;

`ifdef MEM_BYTE_PORT_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_byte_port_if #(.ADDR_WIDTH(AW)) mbi ();

  mem_byte_port #(.ADDR_WIDTH(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (mbi.slave)
  );

  logic [15:0] ram     [0:4095];
  logic [15:0] ref_mem [0:4095];
  int checks   = 0;
  int failures = 0;
  int wr_count = 0;

  // synchronous memory behind the adapter: one-cycle read latency
  always @(posedge clk) begin
    if (mbi.mem_enable_o && mbi.mem_wr_en_o) begin
      ram[mbi.mem_addr_o] <= mbi.mem_value_o;
      wr_count <= wr_count + 1;
    end
    if (mbi.mem_enable_o && mbi.mem_rd_en_o) begin
      mbi.mem_value_i <= ram[mbi.mem_addr_o];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request (called at a negedge) and check cycles N+1..N+3 after the accept.
  task automatic run_req(input logic we, input logic sz, input logic [12:0] a, input logic [15:0] wd);
    int budget;
    int sh;
    int exp_rsp;
    int exp_rd;
    int exp_wr;
    logic [11:0] w;
    logic [15:0] cur;
    logic [15:0] exp_rdata;
    logic [15:0] exp_val;
    logic exp_err;
    w = a[12:1];
    sh = a[0] ? 8 : 0;
    cur = ref_mem[w];
    exp_rd = 0; exp_wr = 0; exp_err = 1'b0; exp_rdata = 16'h0000; exp_val = 16'h0000;
    if (sz && a[0] && ALIGN_EN) begin
      exp_rsp = 1; exp_err = 1'b1;
    end else if (!we) begin
      exp_rsp = 2; exp_rd = 1;
      exp_rdata = sz ? cur : ((cur >> sh) & 16'h00FF);
    end else if (sz) begin
      exp_rsp = 1; exp_wr = 1; exp_val = wd;
    end else begin
      exp_rsp = 3; exp_rd = 1; exp_wr = 3;
      exp_val = (cur & ~(16'h00FF << sh)) | ({8'h00, wd[7:0]} << sh);
    end
    mbi.req_valid_i = 1'b1;
    mbi.req_we_i    = we;
    mbi.req_size_i  = sz;
    mbi.req_addr_i  = a;
    mbi.req_wdata_i = wd;
    budget = 0;
    while (mbi.req_ready_o !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 20) begin
      chk("ready_timeout", 32'd0, 32'd1);
      mbi.req_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    mbi.req_valid_i = 1'b0;
    mbi.req_we_i    = 1'($urandom);
    mbi.req_size_i  = 1'($urandom);
    mbi.req_addr_i  = 13'($urandom);
    mbi.req_wdata_i = 16'($urandom);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("rsp_valid a=%0h k=%0d", a, k), 32'(mbi.rsp_valid_o), 32'(k == exp_rsp));
      chk($sformatf("rsp_rdata a=%0h k=%0d", a, k), 32'(mbi.rsp_rdata_o), 32'((k == exp_rsp) ? exp_rdata : 16'h0000));
      chk($sformatf("rsp_err a=%0h k=%0d", a, k), 32'(mbi.rsp_err_o), 32'((k == exp_rsp) && exp_err));
      chk($sformatf("rd_en a=%0h k=%0d", a, k), 32'(mbi.mem_rd_en_o), 32'(k == exp_rd));
      chk($sformatf("wr_en a=%0h k=%0d", a, k), 32'(mbi.mem_wr_en_o), 32'(k == exp_wr));
      chk($sformatf("enable a=%0h k=%0d", a, k), 32'(mbi.mem_enable_o), 32'((k == exp_rd) || (k == exp_wr)));
      if (k == exp_rd || k == exp_wr) begin
        chk($sformatf("mem_addr a=%0h k=%0d", a, k), 32'(mbi.mem_addr_o), 32'(w));
      end
      if (k == exp_wr) begin
        chk($sformatf("mem_value a=%0h k=%0d", a, k), 32'(mbi.mem_value_o), 32'(exp_val));
      end
    end
    if (exp_wr != 0) begin
      ref_mem[w] = exp_val;
    end
  endtask

  initial begin
    int budget;
    int base;
    int acc;
    logic [15:0] v;
    logic [15:0] e1;
    logic [15:0] e2;
    rst = 1'b1;
    mbi.req_valid_i = 1'b0;
    mbi.req_we_i    = 1'b0;
    mbi.req_size_i  = 1'b0;
    mbi.req_addr_i  = 13'h0000;
    mbi.req_wdata_i = 16'h0000;
    for (int i = 0; i < 4096; i++) begin
      v = 16'($urandom);
      ram[i] = v;
      ref_mem[i] = v;
    end
    ram[5] = 16'hBEEF; ref_mem[5] = 16'hBEEF;
    ram[8] = 16'h0000; ref_mem[8] = 16'h0000;

    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(mbi.req_ready_o), 32'd0);
    chk("reset_rsp_valid", 32'(mbi.rsp_valid_o), 32'd0);
    chk("reset_enable", 32'(mbi.mem_enable_o), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 32'(mbi.req_ready_o), 32'd1);
    chk("post_reset_rsp_valid", 32'(mbi.rsp_valid_o), 32'd0);
    chk("post_reset_rdata", 32'(mbi.rsp_rdata_o), 32'd0);
    chk("post_reset_err", 32'(mbi.rsp_err_o), 32'd0);
    chk("post_reset_rd_en", 32'(mbi.mem_rd_en_o), 32'd0);
    chk("post_reset_wr_en", 32'(mbi.mem_wr_en_o), 32'd0);
    chk("post_reset_mem_addr", 32'(mbi.mem_addr_o), 32'd0);
    chk("post_reset_mem_value", 32'(mbi.mem_value_o), 32'd0);
    @(negedge clk);

    // directed scenarios
    run_req(1'b0, 1'b0, 13'h00B, 16'h0000);
    run_req(1'b1, 1'b0, 13'h00A, 16'h1142);
    run_req(1'b0, 1'b1, 13'h00A, 16'h0000);
    run_req(1'b1, 1'b1, 13'h010, 16'h1234);
    run_req(1'b0, 1'b1, 13'h010, 16'h0000);
    run_req(1'b0, 1'b1, 13'h011, 16'h0000);
    run_req(1'b1, 1'b1, 13'h011, 16'h5678);
    run_req(1'b0, 1'b1, 13'h010, 16'h0000);

    // reset during RD_WAIT of a byte store aborts the write
    mbi.req_valid_i = 1'b1;
    mbi.req_we_i    = 1'b1;
    mbi.req_size_i  = 1'b0;
    mbi.req_addr_i  = 13'h00B;
    mbi.req_wdata_i = 16'h0077;
    budget = 0;
    while (mbi.req_ready_o !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("rst_test_ready_wait", 32'(budget < 20), 32'd1);
    @(posedge clk);
    #1;
    mbi.req_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_test_rd_en", 32'(mbi.mem_rd_en_o), 32'd1);
    @(negedge clk);
    base = wr_count;
    rst = 1'b1;
    #1;
    chk("rst_test_ready_forced", 32'(mbi.req_ready_o), 32'd0);
    chk("rst_test_rsp_forced", 32'(mbi.rsp_valid_o), 32'd0);
    @(negedge clk);
    chk("rst_test_wr_en_held", 32'(mbi.mem_wr_en_o), 32'd0);
    chk("rst_test_ready_held", 32'(mbi.req_ready_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_test_ready_after", 32'(mbi.req_ready_o), 32'd1);
    repeat (3) @(negedge clk);
    chk("rst_test_no_write", 32'(wr_count), 32'(base));
    chk("rst_test_word5", 32'(ram[5]), 32'(ref_mem[5]));
    run_req(1'b0, 1'b1, 13'h00A, 16'h0000);

    // held valid: two loads back to back, one accept every 3 cycles
    run_req(1'b1, 1'b1, 13'h00A, 16'hBEEF);
    e1 = (ref_mem[5] >> 0) & 16'h00FF;
    e2 = (ref_mem[5] >> 8) & 16'h00FF;
    mbi.req_valid_i = 1'b1;
    mbi.req_we_i    = 1'b0;
    mbi.req_size_i  = 1'b0;
    mbi.req_addr_i  = 13'h00A;
    budget = 0;
    while (mbi.req_ready_o !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    acc = 0;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("held_ready k=%0d", k), 32'(mbi.req_ready_o), 32'((k == 0) || (k == 3) || (k >= 6)));
      chk($sformatf("held_rsp_valid k=%0d", k), 32'(mbi.rsp_valid_o), 32'((k == 2) || (k == 5)));
      chk($sformatf("held_rdata k=%0d", k), 32'(mbi.rsp_rdata_o),
          32'((k == 2) ? e1 : ((k == 5) ? e2 : 16'h0000)));
      if (mbi.req_ready_o === 1'b1 && mbi.req_valid_i === 1'b1) begin
        acc++;
      end
      @(posedge clk);
      #1;
      if (acc == 1) begin
        mbi.req_addr_i = 13'h00B;
      end else if (acc >= 2) begin
        mbi.req_valid_i = 1'b0;
      end
      @(negedge clk);
    end
    chk("held_accepts", 32'(acc), 32'd2);

    // top of the address space
    run_req(1'b1, 1'b1, 13'h1FFE, 16'hA55A);
    run_req(1'b0, 1'b0, 13'h1FFF, 16'h0000);
    run_req(1'b1, 1'b0, 13'h1FFF, 16'h00C3);
    run_req(1'b0, 1'b1, 13'h1FFE, 16'h0000);

    // random traffic over a small window so loads see earlier stores
    for (int i = 0; i < 40; i++) begin
      run_req(1'($urandom), 1'($urandom), 13'($urandom_range(0, 127)), 16'($urandom));
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("final_word %0d", i), 32'(ram[i]), 32'(ref_mem[i]));
    end
    chk("final_word 4095", 32'(ram[4095]), 32'(ref_mem[4095]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
